// File: rtl/fc_layer_engine.sv
// rtl/fc_layer_engine.sv - fully-connected layer engine with lane-parallel MAC pipeline
module fc_layer_engine #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int IN_LEN     = 400,
   parameter int OUT_LEN    = 120,
   parameter int LANES      = 16,
   parameter int ACC_WIDTH  = 40,
   parameter bit RELU_EN    = 1'b1,
   localparam int CHUNKS    = (IN_LEN + LANES - 1) / LANES,
   localparam int IAW       = (CHUNKS > 1) ? $clog2(CHUNKS) : 1,
   localparam int WAW       = (OUT_LEN * CHUNKS > 1) ? $clog2(OUT_LEN * CHUNKS) : 1,
   localparam int BAW       = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic [IAW-1:0]                in_addr,
   input  logic [LANES*DATA_WIDTH-1:0]   in_data,
   output logic [WAW-1:0]                w_addr,
   input  logic [LANES*DATA_WIDTH-1:0]   w_data,
   output logic [BAW-1:0]                b_addr,
   input  logic [DATA_WIDTH-1:0]         b_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [BAW-1:0]                out_index
);

   localparam int DW = DATA_WIDTH;
   localparam int AW = ACC_WIDTH;
   localparam int PW = 2 * DW;
   localparam int TW = PW + $clog2(LANES);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_EMIT  = 2'd3;

   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   // control state
   logic [1:0]     state_q, state_d;
   logic [BAW-1:0] neuron_q, neuron_d;
   logic [IAW-1:0] chunk_q, chunk_d;
   logic [1:0]     drain_q, drain_d;
   logic [IAW-1:0] in_addr_q, in_addr_d;
   logic [WAW-1:0] w_addr_q, w_addr_d;
   logic [BAW-1:0] b_addr_q, b_addr_d;
   logic           done_q, done_d;
   logic [DW-1:0]  out_data_q, out_data_d;
   logic [BAW-1:0] out_index_q, out_index_d;
   logic           acc_clr;

   // datapath pipeline
   logic                  v1_q, v2_q, v3_q;
   logic [IAW-1:0]        chunk1_q;
   logic signed [DW-1:0]  bias_q;
   logic signed [DW-1:0]  a_c [LANES];
   logic signed [DW-1:0]  b_c [LANES];
   logic signed [PW-1:0]  prod_c [LANES];
   logic signed [PW-1:0]  prod_q [LANES];
   logic signed [TW-1:0]  tree_c, tree_q;
   logic signed [AW-1:0]  acc_q;
   logic signed [AW-1:0]  sum_c, scaled_c;
   logic [DW-1:0]         result_c;

   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_EMIT);
   assign done      = done_q;
   assign in_addr   = in_addr_q;
   assign w_addr    = w_addr_q;
   assign b_addr    = b_addr_q;
   assign out_data  = out_data_q;
   assign out_index = out_index_q;

   // sequencing: walk chunks per neuron, wait for the pipeline, then hand the result out
   always_comb begin
      state_d     = state_q;
      neuron_d    = neuron_q;
      chunk_d     = chunk_q;
      drain_d     = drain_q;
      in_addr_d   = in_addr_q;
      w_addr_d    = w_addr_q;
      b_addr_d    = b_addr_q;
      done_d      = 1'b0;
      out_data_d  = out_data_q;
      out_index_d = out_index_q;
      acc_clr     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_FETCH;
               neuron_d  = '0;
               chunk_d   = '0;
               in_addr_d = '0;
               w_addr_d  = '0;
               b_addr_d  = '0;
               acc_clr   = 1'b1;
            end
         end
         S_FETCH: begin
            if (chunk_q == IAW'(CHUNKS - 1)) begin
               state_d = S_DRAIN;
               drain_d = '0;
            end else begin
               chunk_d   = chunk_q + IAW'(1);
               in_addr_d = chunk_q + IAW'(1);
               w_addr_d  = w_addr_q + WAW'(1);
            end
         end
         S_DRAIN: begin
            if (drain_q == 2'd3) begin
               state_d     = S_EMIT;
               out_data_d  = result_c;
               out_index_d = neuron_q;
            end else begin
               drain_d = drain_q + 2'd1;
            end
         end
         default: begin
            if (out_ready) begin
               if (neuron_q == BAW'(OUT_LEN - 1)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  // weight rows are contiguous, so the next neuron's chunk 0 follows directly
                  state_d   = S_FETCH;
                  neuron_d  = neuron_q + BAW'(1);
                  chunk_d   = '0;
                  in_addr_d = '0;
                  w_addr_d  = w_addr_q + WAW'(1);
                  b_addr_d  = neuron_q + BAW'(1);
                  acc_clr   = 1'b1;
               end
            end
         end
      endcase
   end

   // control registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         neuron_q    <= '0;
         chunk_q     <= '0;
         drain_q     <= '0;
         in_addr_q   <= '0;
         w_addr_q    <= '0;
         b_addr_q    <= '0;
         done_q      <= 1'b0;
         out_data_q  <= '0;
         out_index_q <= '0;
      end else begin
         state_q     <= state_d;
         neuron_q    <= neuron_d;
         chunk_q     <= chunk_d;
         drain_q     <= drain_d;
         in_addr_q   <= in_addr_d;
         w_addr_q    <= w_addr_d;
         b_addr_q    <= b_addr_d;
         done_q      <= done_d;
         out_data_q  <= out_data_d;
         out_index_q <= out_index_d;
      end
   end

   // lane products; lanes past the end of the input vector are forced to zero
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         a_c[l]    = in_data[l*DW +: DW];
         b_c[l]    = w_data[l*DW +: DW];
         prod_c[l] = PW'(a_c[l]) * PW'(b_c[l]);
         if (32'(chunk1_q) * 32'(LANES) + 32'(l) >= 32'(IN_LEN)) begin
            prod_c[l] = '0;
         end
      end
   end

   // lane-sum reduction
   always_comb begin
      tree_c = '0;
      for (int l = 0; l < LANES; l++) begin
         tree_c = tree_c + TW'(prod_q[l]);
      end
   end

   // bias alignment, rescale, saturate and optional rectification
   always_comb begin
      sum_c    = acc_q + (AW'(bias_q) <<< FRAC_BITS);
      scaled_c = sum_c >>> FRAC_BITS;
      if (scaled_c > SAT_MAX) begin
         result_c = SAT_MAX[DW-1:0];
      end else if (scaled_c < SAT_MIN) begin
         result_c = SAT_MIN[DW-1:0];
      end else begin
         result_c = scaled_c[DW-1:0];
      end
      if (RELU_EN && result_c[DW-1]) begin
         result_c = '0;
      end
   end

   // memory-data, product, tree and accumulate stages
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         v3_q     <= 1'b0;
         chunk1_q <= '0;
         bias_q   <= '0;
         for (int l = 0; l < LANES; l++) begin
            prod_q[l] <= '0;
         end
         tree_q   <= '0;
         acc_q    <= '0;
      end else begin
         v1_q     <= (state_q == S_FETCH);
         chunk1_q <= chunk_q;
         v2_q     <= v1_q;
         v3_q     <= v2_q;
         if (v1_q) begin
            bias_q <= b_data;
            for (int l = 0; l < LANES; l++) begin
               prod_q[l] <= prod_c[l];
            end
         end
         if (v2_q) begin
            tree_q <= tree_c;
         end
         if (acc_clr) begin
            acc_q <= '0;
         end else if (v3_q) begin
            acc_q <= acc_q + AW'(tree_q);
         end
      end
   end

endmodule

// File: tb/tb_fc_layer_engine.sv
// tb/tb_fc_layer_engine.sv - randomized self-checking bench for fc_layer_engine
module tb_fc_layer_engine;

   localparam int DW  = 16;
   localparam int FB  = 8;
   localparam int IL  = 6;
   localparam int OL  = 3;
   localparam int LN  = 4;
   localparam int AW  = 40;
   localparam int CH  = 2;
   localparam int IAW = 1;
   localparam int WAW = 3;
   localparam int BAW = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             out_ready = 1'b1;
   logic [LN*DW-1:0] in_data, w_data;
   logic [DW-1:0]    b_data;

   logic             r_busy, r_done, r_out_valid, l_busy, l_done, l_out_valid;
   logic [IAW-1:0]   r_in_addr, l_in_addr;
   logic [WAW-1:0]   r_w_addr, l_w_addr;
   logic [BAW-1:0]   r_b_addr, l_b_addr, r_out_index, l_out_index;
   logic [DW-1:0]    r_out_data, l_out_data;

   logic [15:0] in_mem [CH*LN];
   logic [15:0] w_mem  [OL*CH*LN];
   logic [15:0] b_mem  [OL];

   int cyc = 0;
   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fc_layer_engine #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .IN_LEN(IL), .OUT_LEN(OL),
                     .LANES(LN), .ACC_WIDTH(AW), .RELU_EN(1'b1)) dut_relu (
      .clk(clk), .rst(rst), .start(start), .busy(r_busy), .done(r_done),
      .in_addr(r_in_addr), .in_data(in_data), .w_addr(r_w_addr), .w_data(w_data),
      .b_addr(r_b_addr), .b_data(b_data), .out_valid(r_out_valid), .out_ready(out_ready),
      .out_data(r_out_data), .out_index(r_out_index));

   fc_layer_engine #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .IN_LEN(IL), .OUT_LEN(OL),
                     .LANES(LN), .ACC_WIDTH(AW), .RELU_EN(1'b0)) dut_lin (
      .clk(clk), .rst(rst), .start(start), .busy(l_busy), .done(l_done),
      .in_addr(l_in_addr), .in_data(in_data), .w_addr(l_w_addr), .w_data(w_data),
      .b_addr(l_b_addr), .b_data(b_data), .out_valid(l_out_valid), .out_ready(out_ready),
      .out_data(l_out_data), .out_index(l_out_index));

   // synchronous block memories, one cycle read latency
   always @(posedge clk) begin
      for (int l = 0; l < LN; l++) begin
         in_data[l*DW +: DW] <= in_mem[int'(r_in_addr)*LN + l];
         w_data[l*DW +: DW]  <= (int'(r_w_addr) < OL*CH) ? w_mem[int'(r_w_addr)*LN + l] : 16'h0;
      end
      b_data <= (int'(r_b_addr) < OL) ? b_mem[r_b_addr] : 16'h0;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // out[j] = sat(floor(dot/2^FB) + bias), optionally clipped at zero
   function automatic logic [15:0] ref_out(input int j, input bit relu);
      longint dot = 0;
      longint r;
      for (int i = 0; i < IL; i++)
         dot += longint'($signed(in_mem[i])) * longint'($signed(w_mem[j*CH*LN + i]));
      r = (dot >>> FB) + longint'($signed(b_mem[j]));
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      if (relu && r < 0) r = 0;
      return 16'(r);
   endfunction

   function automatic logic [15:0] rnd_word(input int mode);
      if (mode == 1) return 16'($urandom_range(0, 1023)) - 16'd512;
      return 16'($urandom);
   endfunction

   // mode 0: constants, 1: small random, 2: full-range random; pad fills masked lanes
   task automatic set_layer(input int mode, input logic [15:0] iv, input logic [15:0] wv,
                            input logic [15:0] bv, input logic [15:0] pad);
      for (int i = 0; i < CH*LN; i++) begin
         in_mem[i] = (i >= IL) ? pad : (mode == 0) ? iv : rnd_word(mode);
         for (int j = 0; j < OL; j++)
            w_mem[j*CH*LN + i] = (i >= IL) ? pad : (mode == 0) ? wv : rnd_word(mode);
      end
      for (int j = 0; j < OL; j++) b_mem[j] = (mode == 0) ? bv : rnd_word(1);
   endtask

   task automatic check_emit(input string nm, input int j);
      chk($sformatf("%s.n%0d.valid", nm, j), r_out_valid, 1);
      chk($sformatf("%s.n%0d.data_relu", nm, j), r_out_data, ref_out(j, 1'b1));
      chk($sformatf("%s.n%0d.data_lin", nm, j), l_out_data, ref_out(j, 1'b0));
      chk($sformatf("%s.n%0d.index", nm, j), r_out_index, j);
      chk($sformatf("%s.n%0d.index_lin", nm, j), l_out_index, j);
      chk($sformatf("%s.n%0d.in_addr", nm, j), r_in_addr, CH - 1);
      chk($sformatf("%s.n%0d.w_addr", nm, j), r_w_addr, j*CH + CH - 1);
      chk($sformatf("%s.n%0d.b_addr", nm, j), r_b_addr, j);
      chk($sformatf("%s.n%0d.busy", nm, j), r_busy, 1);
   endtask

   // called and returns at posedge+1
   task automatic run_layer(input int stall_n, input string nm);
      int L, n;
      start = 1'b1;
      L = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      for (int j = 0; j < OL; j++) begin
         n = 0;
         while (!r_out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
         end
         chk($sformatf("%s.n%0d.latency", nm, j), cyc - L, 7);
         if (!r_out_valid) return;
         check_emit(nm, j);
         if (j == stall_n) begin
            out_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               start = (k == 0);
               @(posedge clk); #1;
               start = 1'b0;
               check_emit($sformatf("%s.stall%0d", nm, k), j);
            end
            out_ready = 1'b1;
         end
         L = cyc;
         @(posedge clk); #1;
      end
      chk($sformatf("%s.done", nm), r_done, 1);
      chk($sformatf("%s.done_lin", nm), l_done, 1);
      chk($sformatf("%s.busy_end", nm), r_busy, 0);
      chk($sformatf("%s.valid_end", nm), r_out_valid, 0);
      @(posedge clk); #1;
      chk($sformatf("%s.done_pulse", nm), r_done, 0);
   endtask

   task automatic reset_abort();
      int n, dones;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!r_out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("abort.first_index", r_out_index, 0);
      @(posedge clk); #1;
      chk("abort.busy_fetch", r_busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("abort.busy_async", r_busy, 0);
      chk("abort.valid_async", r_out_valid, 0);
      chk("abort.done_async", r_done, 0);
      @(posedge clk); #1;
      chk("abort.in_addr", r_in_addr, 0);
      chk("abort.w_addr", r_w_addr, 0);
      chk("abort.b_addr", r_b_addr, 0);
      chk("abort.out_index", r_out_index, 0);
      rst = 1'b0;
      dones = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (r_done || l_done || r_busy) dones++;
      end
      chk("abort.quiet", dones, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      set_layer(0, 16'h0100, 16'h0080, 16'h0000, 16'h1234);
      repeat (3) @(posedge clk);
      #1;
      chk("rst.busy", r_busy, 0);
      chk("rst.done", r_done, 0);
      chk("rst.out_valid", r_out_valid, 0);
      chk("rst.out_data", r_out_data, 0);
      chk("rst.out_index", r_out_index, 0);
      chk("rst.in_addr", r_in_addr, 0);
      chk("rst.w_addr", r_w_addr, 0);
      chk("rst.b_addr", r_b_addr, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      set_layer(0, 16'h0100, 16'h0080, 16'h0000, 16'($urandom));
      chk("basic.model", ref_out(0, 1'b1), 16'h0300);
      run_layer(-1, "basic");

      set_layer(0, 16'h0100, 16'h0080, 16'h0000, 16'h7FFF);
      run_layer(-1, "mask");

      set_layer(0, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000);
      run_layer(-1, "satpos");

      set_layer(0, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000);
      run_layer(-1, "satneg");

      set_layer(0, 16'h0100, 16'hFF80, 16'h0000, 16'h7FFF);
      run_layer(-1, "neg");

      set_layer(0, 16'h0100, 16'hFF80, 16'h0400, 16'h7FFF);
      run_layer(-1, "biased");

      set_layer(1, 16'h0, 16'h0, 16'h0, 16'($urandom));
      run_layer(1, "stall");

      set_layer(1, 16'h0, 16'h0, 16'h0, 16'($urandom));
      reset_abort();
      run_layer(-1, "after_abort");

      for (int t = 0; t < 6; t++) begin
         set_layer((t % 2) + 1, 16'h0, 16'h0, 16'h0, 16'($urandom));
         run_layer(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, OL-1)) : -1,
                   $sformatf("rand%0d", t));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/fc_layer_engine.md
# fc_layer_engine

Parametrised fully-connected layer engine for the LeNet-5 datapath (FC1/FC2/FC3). It computes out[j] = sat(bias[j] + Σ in[i]·W[j][i]) for an IN_LEN-element input vector and OUT_LEN neurons. Each cycle it consumes LANES input/weight pairs from synchronous block memories. Results are streamed out one neuron at a time over a valid/ready handshake, with optional ReLU.

## Interface
- DATA_WIDTH, 16: signed fixed-point word width (inputs, weights, bias, outputs).
- FRAC_BITS, 8: fractional bits of every word.
- IN_LEN, 400: input vector length.
- OUT_LEN, 120: number of output neurons.
- LANES, 16: multipliers per cycle; CHUNKS = ceil(IN_LEN/LANES).
- ACC_WIDTH, 40: signed accumulator width.
- RELU_EN, 1: 1 applies ReLU after saturation.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after last output handshake.
- in_addr  out  clog2(CHUNKS)  input-buffer chunk address.
- in_data  in  LANES*DATA_WIDTH  chunk data, lane 0 in LSBs; valid 1 cycle after in_addr.
- w_addr  out  clog2(OUT_LEN*CHUNKS)  weight address = neuron*CHUNKS + chunk.
- w_data  in  LANES*DATA_WIDTH  weight chunk; valid 1 cycle after w_addr.
- b_addr  out  clog2(OUT_LEN)  bias address = neuron index.
- b_data  in  DATA_WIDTH  bias; valid 1 cycle after b_addr.
- out_valid  out  1  out_data/out_index valid.
- out_ready  in  1  consumer accepts when high with out_valid.
- out_data  out  DATA_WIDTH  neuron result.
- out_index  out  clog2(OUT_LEN)  neuron index of out_data.

## Operation
- FSM: IDLE -> FETCH -> DRAIN -> EMIT -> (FETCH next neuron | IDLE).
- IDLE: start -> FETCH with neuron=0, chunk=0, accumulator cleared, busy=1.
- FETCH: CHUNKS cycles. Drives in_addr=chunk, w_addr=neuron*CHUNKS+chunk, b_addr=neuron; chunk increments each cycle.
- Pipeline per chunk: memory data (+1), LANES signed products registered (+2), lane-sum tree registered (+3), accumulate (+4).
- Lane mask: in the last chunk, lanes with index chunk*LANES+lane >= IN_LEN contribute 0 regardless of memory contents.
- Widths: product 2*DATA_WIDTH; tree sum 2*DATA_WIDTH+clog2(LANES); both sign-extended into ACC_WIDTH. Bias is sign-extended and shifted left by FRAC_BITS before addition.
- Result: (acc+bias)>>>FRAC_BITS (arithmetic, truncation), saturated to [-2^(DW-1), 2^(DW-1)-1], then ReLU (negative -> 0) if RELU_EN.
- DRAIN: 4 cycles; the last cycle loads out_data/out_index.
- EMIT: out_valid=1, outputs held stable until out_ready. On handshake, neuron<OUT_LEN-1 -> FETCH (acc cleared, neuron+1); else -> IDLE with done pulse.
- start while busy is ignored.
- rst at any time: immediately to IDLE, counters and accumulator zero, no done pulse; the aborted layer is discarded.

## Timing
- Reset values: busy=0, done=0, out_valid=0, out_data=0, out_index=0, in_addr=0, w_addr=0, b_addr=0.
- start sampled high in IDLE at edge E: FETCH occupies the following CHUNKS cycles.
- out_valid rises CHUNKS+4 cycles after FETCH entry.
- With out_ready tied high, each neuron takes CHUNKS+5 cycles and a layer takes OUT_LEN*(CHUNKS+5).
- done is high the cycle after the final handshake; busy falls in the same cycle.
- Memory addresses hold their last value outside FETCH and are don't-care.

## Test plan
- DW=16, FRAC=8, LANES=4, IN_LEN=6, OUT_LEN=3, all inputs 0x0100, all weights 0x0080, bias 0 -> out_data 0x0300 for indices 0,1,2. Each out_valid comes 7 cycles apart; done arrives 1 cycle after the third handshake.
- Same setup, lanes 2–3 of chunk 1 hold 0x7FFF in both memories -> results still 0x0300 (masking).
- Inputs 0x7FFF, weights 0x7FFF -> 0x7FFF (positive saturation). Weights 0x8000, inputs 0x7FFF with RELU_EN=0 -> 0x8000.
- Weights 0xFF80, bias 0x0000: RELU_EN=0 -> 0xFD00; RELU_EN=1 -> 0x0000. With bias 0x0400 and RELU_EN=1 -> 0x0100.
- out_ready low for 5 cycles during EMIT of neuron 1 -> out_valid held, out_data/out_index stable, no address activity; resumes correctly after out_ready goes high.
- rst pulsed mid-FETCH of neuron 1 -> busy=0, out_valid=0 asynchronously, no done. A following start produces a full correct layer from index 0.
